// File: rtl/hazard_ctrl_param.sv
// Stateful hazard/stall controller for the in-order rv32i pipeline.
// Drives per-stage load/flush enables and saturating stall/flush counters.
module hazard_ctrl_param #(
  parameter int NUM_STAGES       = 5,
  parameter int BR_RESOLVE_STAGE = 2,
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int REG_IDX_W        = 5,
  parameter int CNT_W            = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  inst_read,
  input  logic                  inst_resp,
  input  logic                  data_req,
  input  logic                  data_resp,
  input  logic                  ex_is_load,
  input  logic [REG_IDX_W-1:0]  ex_rd,
  input  logic [REG_IDX_W-1:0]  id_rs1,
  input  logic [REG_IDX_W-1:0]  id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  redirect,
  output logic                  load_pc,
  output logic [NUM_STAGES-2:0] load_stage,
  output logic [NUM_STAGES-2:0] rst_stage,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam int NR = NUM_STAGES - 1;
  localparam logic [NR-1:0] ONES = '1;
  localparam logic [NR-1:0] REDIR_MASK =
    ONES >> (NR - BR_RESOLVE_STAGE);
  localparam logic [NR-1:0] STG0 = NR'(1);
  localparam logic [NR-1:0] STG1 = NR'(2);
  localparam logic [2:0] LU_INIT = 3'(LOAD_USE_BUBBLES - 1);

  typedef enum logic [1:0] {
    RUN,
    LU_STALL,
    SQUASH
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             dmem_stall;
  logic             lu_hit;
  logic             flush_inc;

  assign dmem_stall = data_req & ~data_resp;
  assign lu_hit = ex_is_load & (ex_rd != '0) &
    ((id_uses_rs1 & (id_rs1 == ex_rd)) |
     (id_uses_rs2 & (id_rs2 == ex_rd)));

  always_comb begin
    state_d    = state_q;
    lu_cnt_d   = lu_cnt_q;
    flush_inc  = 1'b0;
    inst_read  = 1'b1;
    load_pc    = 1'b1;
    load_stage = '1;
    rst_stage  = '0;
    if (dmem_stall) begin
      load_pc    = 1'b0;
      load_stage = '0;
    end else if (state_q == SQUASH) begin
      load_pc   = 1'b0;
      rst_stage = STG0;
      if (inst_resp) begin
        flush_inc = 1'b1;
        state_d   = RUN;
      end
    end else if (redirect) begin
      rst_stage = REDIR_MASK;
      flush_inc = 1'b1;
      lu_cnt_d  = '0;
      state_d   = inst_resp ? RUN : SQUASH;
    end else if (state_q == LU_STALL || lu_hit) begin
      // IF/ID holds; a bubble enters ID/EX even if imem is still busy
      load_pc    = 1'b0;
      load_stage = ~STG0;
      rst_stage  = STG1;
      if (state_q == LU_STALL) begin
        lu_cnt_d = lu_cnt_q - 3'd1;
        if (lu_cnt_q == 3'd1) state_d = RUN;
      end else if (LOAD_USE_BUBBLES > 1) begin
        lu_cnt_d = LU_INIT;
        state_d  = LU_STALL;
      end
    end else if (!inst_resp) begin
      load_pc   = 1'b0;
      rst_stage = STG0;
    end
    if (!rst) begin
      inst_read  = 1'b0;
      load_pc    = 1'b0;
      load_stage = '0;
      rst_stage  = '1;
    end
    stall_cnt_d = stall_cnt_q;
    if (!load_pc && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + 1'b1;
    flush_cnt_d = flush_cnt_q;
    if (flush_inc && flush_cnt_q != '1)
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      lu_cnt_q    <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      lu_cnt_q    <= lu_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_param.sv
// Bench for hazard_ctrl_param: directed scenarios on three builds
// plus randomized traffic against a behavioural pipeline-control model.
module tb_hazard_ctrl_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       inst_resp, data_req, data_resp;
  logic       ex_is_load, id_uses_rs1, id_uses_rs2, redirect;
  logic [4:0] ex_rd, id_rs1, id_rs2;

  logic        a_ir, a_lpc;
  logic [3:0]  a_ls, a_rs;
  logic [31:0] a_sc, a_fc;
  logic        b_ir, b_lpc;
  logic [5:0]  b_ls, b_rs;
  logic [31:0] b_sc, b_fc;
  logic        c_ir, c_lpc;
  logic [3:0]  c_ls, c_rs;
  logic [3:0]  c_sc, c_fc;

  int checks = 0;
  int fails  = 0;

  hazard_ctrl_param dut_a (
    .clk(clk), .rst(rst), .inst_read(a_ir), .inst_resp(inst_resp),
    .data_req(data_req), .data_resp(data_resp),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .redirect(redirect), .load_pc(a_lpc), .load_stage(a_ls),
    .rst_stage(a_rs), .stall_cnt(a_sc), .flush_cnt(a_fc)
  );

  hazard_ctrl_param #(
    .NUM_STAGES(7), .BR_RESOLVE_STAGE(3), .LOAD_USE_BUBBLES(3)
  ) dut_b (
    .clk(clk), .rst(rst), .inst_read(b_ir), .inst_resp(inst_resp),
    .data_req(data_req), .data_resp(data_resp),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .redirect(redirect), .load_pc(b_lpc), .load_stage(b_ls),
    .rst_stage(b_rs), .stall_cnt(b_sc), .flush_cnt(b_fc)
  );

  hazard_ctrl_param #(.CNT_W(4)) dut_c (
    .clk(clk), .rst(rst), .inst_read(c_ir), .inst_resp(inst_resp),
    .data_req(data_req), .data_resp(data_resp),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .redirect(redirect), .load_pc(c_lpc), .load_stage(c_ls),
    .rst_stage(c_rs), .stall_cnt(c_sc), .flush_cnt(c_fc)
  );

  // Per-build view of the outputs, widened for the model compare
  logic        o_ir[3], o_lpc[3];
  logic [7:0]  o_ls[3], o_rs[3];
  logic [63:0] o_sc[3], o_fc[3];
  always_comb begin
    o_ir[0] = a_ir; o_lpc[0] = a_lpc;
    o_ir[1] = b_ir; o_lpc[1] = b_lpc;
    o_ir[2] = c_ir; o_lpc[2] = c_lpc;
    o_ls[0] = 8'(a_ls); o_rs[0] = 8'(a_rs);
    o_ls[1] = 8'(b_ls); o_rs[1] = 8'(b_rs);
    o_ls[2] = 8'(c_ls); o_rs[2] = 8'(c_rs);
    o_sc[0] = 64'(a_sc); o_fc[0] = 64'(a_fc);
    o_sc[1] = 64'(b_sc); o_fc[1] = 64'(b_fc);
    o_sc[2] = 64'(c_sc); o_fc[2] = 64'(c_fc);
  end

  int          NS[3]   = '{5, 7, 5};
  int          BR[3]   = '{2, 3, 2};
  int          BUB[3]  = '{1, 3, 1};
  logic [63:0] CMAX[3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};

  // Model: a pending stale fetch, bubbles still owed, two tallies
  bit          m_pend[3];
  int          m_left[3];
  logic [63:0] m_sc[3], m_fc[3];

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      m_pend[i] = 0; m_left[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
    end
  endtask

  task automatic model_eval(
    input int i, output bit ir, output bit lpc,
    output logic [7:0] ls, output logic [7:0] rs,
    output bit npend, output int nleft,
    output bit sinc, output bit finc);
    logic [7:0] full;
    bit haz;
    full = 8'((1 << (NS[i] - 1)) - 1);
    haz = ex_is_load && ex_rd != 0 &&
      ((id_uses_rs1 && id_rs1 == ex_rd) ||
       (id_uses_rs2 && id_rs2 == ex_rd));
    ir = 1; lpc = 1; ls = full; rs = 0;
    npend = m_pend[i]; nleft = m_left[i]; finc = 0;
    if (!rst) begin
      ir = 0; lpc = 0; ls = 0; rs = full; npend = 0; nleft = 0;
    end else if (data_req && !data_resp) begin
      lpc = 0; ls = 0;
    end else if (m_pend[i]) begin
      lpc = 0; rs = 8'd1;
      if (inst_resp) begin finc = 1; npend = 0; end
    end else if (redirect) begin
      rs = 8'((1 << BR[i]) - 1);
      finc = 1; nleft = 0; npend = !inst_resp;
    end else if (m_left[i] > 0 || haz) begin
      lpc = 0; ls = full & ~8'd1; rs = 8'd2;
      nleft = (m_left[i] > 0) ? m_left[i] - 1 : BUB[i] - 1;
    end else if (!inst_resp) begin
      lpc = 0; rs = 8'd1;
    end
    sinc = rst && !lpc;
  endtask

  task automatic tick();
    bit ir, lpc;
    logic [7:0] ls, rs;
    bit np[3], si[3], fi[3];
    int nl[3];
    for (int i = 0; i < 3; i++)
      model_eval(i, ir, lpc, ls, rs, np[i], nl[i], si[i], fi[i]);
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_pend[i] = np[i]; m_left[i] = nl[i];
        if (si[i] && m_sc[i] < CMAX[i]) m_sc[i] = m_sc[i] + 1;
        if (fi[i] && m_fc[i] < CMAX[i]) m_fc[i] = m_fc[i] + 1;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    inst_resp = 1; data_req = 0; data_resp = 0; redirect = 0;
    ex_is_load = 0; ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
    id_uses_rs1 = 0; id_uses_rs2 = 0;
  endtask

  task automatic do_reset();
    rst = 0;
    idle_inputs();
    model_clear();
    @(posedge clk);
    #1;
    rst = 1;
  endtask

  task automatic test_reset();
    do_reset();
    redirect = 1;
    repeat (6) tick();
    redirect = 0; data_req = 1;
    repeat (7) tick();
    data_req = 0; redirect = 1; inst_resp = 0;
    tick();
    redirect = 0;
    checks++;
    if (a_fc !== 32'd7 || a_sc !== 32'd7) begin
      fails++;
      $display("FAIL pre_reset_cnt: flush=%0d stall=%0d need 7/7",
        a_fc, a_sc);
    end
    rst = 0;
    #1;
    model_clear();
    checks++;
    if ({a_ir, a_lpc, a_ls, a_rs} !== {1'b0, 1'b0, 4'b0000, 4'b1111}) begin
      fails++;
      $display("FAIL reset_out: ir=%b lpc=%b ls=%b rs=%b", a_ir, a_lpc,
        a_ls, a_rs);
    end
    checks++;
    if (a_sc !== 0 || a_fc !== 0 || c_sc !== 0) begin
      fails++;
      $display("FAIL reset_cnt: stall=%0d flush=%0d need 0", a_sc, a_fc);
    end
    @(posedge clk);
    #1;
    rst = 1; inst_resp = 1;
    #1;
    checks++;
    if ({a_lpc, a_ls, a_rs} !== {1'b1, 4'b1111, 4'b0000}) begin
      fails++;
      $display("FAIL post_reset: lpc=%b ls=%b rs=%b need 1/1111/0000",
        a_lpc, a_ls, a_rs);
    end
    tick();
  endtask

  task automatic test_dmem();
    do_reset();
    data_req = 1; data_resp = 0; redirect = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if ({a_ir, a_lpc, a_ls, a_rs} !== {1'b1, 1'b0, 4'b0, 4'b0}) begin
        fails++;
        $display("FAIL dmem_stall%0d: ir=%b lpc=%b ls=%b rs=%b", k,
          a_ir, a_lpc, a_ls, a_rs);
      end
      tick();
    end
    data_resp = 1;
    #1;
    checks++;
    if ({a_lpc, a_ls, a_rs} !== {1'b1, 4'b1111, 4'b0011}) begin
      fails++;
      $display("FAIL dmem_release: lpc=%b ls=%b rs=%b need 1/1111/0011",
        a_lpc, a_ls, a_rs);
    end
    tick();
    checks++;
    if (a_sc !== 32'd3 || a_fc !== 32'd1) begin
      fails++;
      $display("FAIL dmem_cnt: stall=%0d flush=%0d need 3/1", a_sc, a_fc);
    end
    idle_inputs();
  endtask

  task automatic test_load_use();
    do_reset();
    ex_is_load = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1;
    #1;
    checks++;
    if ({a_lpc, a_ls, a_rs} !== {1'b0, 4'b1110, 4'b0010}) begin
      fails++;
      $display("FAIL lu_bubble: lpc=%b ls=%b rs=%b need 0/1110/0010",
        a_lpc, a_ls, a_rs);
    end
    tick();
    ex_is_load = 0;
    #1;
    checks++;
    if ({a_lpc, a_ls, a_rs} !== {1'b1, 4'b1111, 4'b0000}) begin
      fails++;
      $display("FAIL lu_one_bubble: lpc=%b ls=%b rs=%b", a_lpc, a_ls,
        a_rs);
    end
    tick();
    ex_is_load = 1; ex_rd = 0; id_rs1 = 0;
    #1;
    checks++;
    if (a_lpc !== 1'b1 || a_rs !== 4'b0) begin
      fails++;
      $display("FAIL lu_x0: lpc=%b rs=%b need 1/0000", a_lpc, a_rs);
    end
    ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 0;
    #1;
    checks++;
    if (a_lpc !== 1'b1 || a_rs !== 4'b0) begin
      fails++;
      $display("FAIL lu_unused: lpc=%b rs=%b need 1/0000", a_lpc, a_rs);
    end
    id_rs2 = 5; id_uses_rs2 = 1;
    #1;
    checks++;
    if ({a_lpc, a_ls, a_rs} !== {1'b0, 4'b1110, 4'b0010}) begin
      fails++;
      $display("FAIL lu_rs2: lpc=%b ls=%b rs=%b", a_lpc, a_ls, a_rs);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_squash();
    do_reset();
    redirect = 1; inst_resp = 0;
    #1;
    checks++;
    if (a_lpc !== 1'b1 || a_rs !== 4'b0011) begin
      fails++;
      $display("FAIL sq_redirect: lpc=%b rs=%b need 1/0011", a_lpc, a_rs);
    end
    tick();
    redirect = 0;
    checks++;
    if (a_fc !== 32'd1) begin
      fails++;
      $display("FAIL sq_cnt1: flush=%0d need 1", a_fc);
    end
    #1;
    checks++;
    if (a_lpc !== 1'b0 || a_rs !== 4'b0001) begin
      fails++;
      $display("FAIL sq_wait: lpc=%b rs=%b need 0/0001", a_lpc, a_rs);
    end
    tick();
    inst_resp = 1;
    #1;
    checks++;
    if (a_lpc !== 1'b0 || a_rs !== 4'b0001) begin
      fails++;
      $display("FAIL sq_drop: lpc=%b rs=%b need 0/0001", a_lpc, a_rs);
    end
    tick();
    checks++;
    if (a_fc !== 32'd2) begin
      fails++;
      $display("FAIL sq_cnt2: flush=%0d need 2", a_fc);
    end
    #1;
    checks++;
    if ({a_lpc, a_ls, a_rs} !== {1'b1, 4'b1111, 4'b0000}) begin
      fails++;
      $display("FAIL sq_accept: lpc=%b ls=%b rs=%b", a_lpc, a_ls, a_rs);
    end
    tick();
  endtask

  task automatic test_param();
    do_reset();
    ex_is_load = 1; ex_rd = 7; id_rs2 = 7; id_uses_rs2 = 1;
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k < 3 && {b_lpc, b_ls, b_rs} !== {1'b0, 6'b111110, 6'b000010}) begin
        fails++;
        $display("FAIL p_bubble%0d: lpc=%b ls=%b rs=%b", k, b_lpc,
          b_ls, b_rs);
      end else if (k == 3 && {b_lpc, b_rs} !== {1'b1, 6'b0}) begin
        fails++;
        $display("FAIL p_exit: lpc=%b rs=%b need 1/000000", b_lpc, b_rs);
      end
      tick();
      ex_is_load = 0;
    end
    do_reset();
    ex_is_load = 1; ex_rd = 7; id_rs2 = 7; id_uses_rs2 = 1;
    tick();
    ex_is_load = 0; redirect = 1;
    #1;
    checks++;
    if (b_lpc !== 1'b1 || b_rs !== 6'b000111) begin
      fails++;
      $display("FAIL p_redirect: lpc=%b rs=%b need 1/000111", b_lpc, b_rs);
    end
    tick();
    redirect = 0;
    #1;
    checks++;
    if ({b_lpc, b_ls, b_rs} !== {1'b1, 6'b111111, 6'b000000}) begin
      fails++;
      $display("FAIL p_abandon: lpc=%b ls=%b rs=%b", b_lpc, b_ls, b_rs);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_saturation();
    do_reset();
    data_req = 1; data_resp = 0;
    repeat (20) tick();
    checks++;
    if (c_sc !== 4'd15 || a_sc !== 32'd20) begin
      fails++;
      $display("FAIL sat: c_stall=%0d a_stall=%0d need 15/20", c_sc, a_sc);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    bit ir, lpc, np, si, fi;
    logic [7:0] ls, rs;
    int nl;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      data_req    = ($urandom_range(0, 7) == 0);
      data_resp   = 1'($urandom_range(0, 1));
      inst_resp   = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 7) == 0);
      ex_is_load  = 1'($urandom_range(0, 1));
      ex_rd       = 5'($urandom_range(0, 3));
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      id_uses_rs1 = 1'($urandom_range(0, 1));
      id_uses_rs2 = 1'($urandom_range(0, 1));
      #1;
      for (int i = 0; i < 3; i++) begin
        model_eval(i, ir, lpc, ls, rs, np, nl, si, fi);
        checks++;
        if ({o_ir[i], o_lpc[i], o_ls[i], o_rs[i]} !== {ir, lpc, ls, rs}) begin
          fails++;
          $display("FAIL rnd_out[%0d] cyc %0d: got %b/%b/%b/%b need %b/%b/%b/%b",
            i, n, o_ir[i], o_lpc[i], o_ls[i], o_rs[i], ir, lpc, ls, rs);
        end
      end
      tick();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (o_sc[i] !== m_sc[i] || o_fc[i] !== m_fc[i]) begin
          fails++;
          $display("FAIL rnd_cnt[%0d] cyc %0d: got %0d/%0d need %0d/%0d",
            i, n, o_sc[i], o_fc[i], m_sc[i], m_fc[i]);
        end
      end
    end
  endtask

  initial begin
    rst = 0;
    idle_inputs();
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_dmem();
    test_load_use();
    test_squash();
    test_param();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
      checks, fails);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_param.md
Name: hazard_ctrl_param

Overview:
- Parametrised, stateful hazard/stall controller for the in-order rv32i pipeline; replaces the purely combinational hazard detection unit.
- Generates per-stage-register load/flush vectors for an N-stage pipeline.
- Inserts a configurable number of load-use bubbles.
- Squashes a stale instruction-memory response that was already in flight when a branch/jump redirect occurred.
- Keeps saturating stall and flush performance counters.

Parameters:
NUM_STAGES, 5, pipeline stages; stage registers indexed k=0..NUM_STAGES-2 (0=IF/ID, NUM_STAGES-2=MEM/WB)
BR_RESOLVE_STAGE, 2, stage where redirect resolves; legal 1..NUM_STAGES-2; redirect flushes stage regs 0..BR_RESOLVE_STAGE-1
LOAD_USE_BUBBLES, 1, bubbles inserted per load-use hazard; legal 1..7
REG_IDX_W, 5, register index width
CNT_W, 32, perf counter width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
inst_read  out  1  instruction memory request
inst_resp  in  1  instruction memory response (one-cycle pulse)
data_req  in  1  MEM-stage load or store active
data_resp  in  1  data memory response
ex_is_load  in  1  instruction in stage register 1 (ID/EX) is a load
ex_rd  in  REG_IDX_W  that load's destination
id_rs1, id_rs2  in  REG_IDX_W  sources of instruction in IF/ID
id_uses_rs1, id_uses_rs2  in  1  source actually read
redirect  in  1  br_en or jump_en at BR_RESOLVE_STAGE
load_pc  out  1  PC register enable
load_stage  out  NUM_STAGES-1  stage register enables
rst_stage  out  NUM_STAGES-1  synchronous bubble insert, per stage register
stall_cnt  out  CNT_W  cycles with load_pc=0 and rst high
flush_cnt  out  CNT_W  count of redirects plus squashed fetches

Behaviour:
- States: RUN, LU_STALL, SQUASH. Internal bubble counter lu_cnt, 3 bits.
- Reset (rst=0, async):
  - State goes to RUN; lu_cnt=0; counters=0.
  - Outputs while in reset: inst_read=0, load_pc=0, load_stage=0, rst_stage all 1.
  - Reset mid-stall or mid-squash abandons the operation with no residue.
- Defaults: inst_read=1, load_pc=1, load_stage all 1, rst_stage all 0.
- Priority rules, highest first:
  - P1 dmem stall (data_req & ~data_resp):
    - load_pc=0, load_stage=0, rst_stage=0.
    - inst_read stays 1; an outstanding fetch is never dropped.
    - State and lu_cnt hold.
    - redirect and load-use are ignored this cycle; frozen stage registers keep re-presenting them.
  - P2 SQUASH with inst_resp=1:
    - Stale fetch arrives: rst_stage[0]=1, load_pc=0, flush_cnt+1, next state RUN.
  - P2 SQUASH with inst_resp=0:
    - load_pc=0, rst_stage[0]=1.
  - P3 redirect=1 (RUN or LU_STALL):
    - rst_stage[k]=1 for k<BR_RESOLVE_STAGE; load_pc=1; flush_cnt+1.
    - Any LU_STALL is abandoned.
    - If inst_resp=0 (fetch outstanding), next state SQUASH, otherwise RUN.
  - P4 load-use hazard: ex_is_load & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)), in RUN:
    - load_pc=0, load_stage[0]=0, rst_stage[1]=1.
    - If LOAD_USE_BUBBLES>1: lu_cnt=LOAD_USE_BUBBLES-1, next state LU_STALL.
  - P4 LU_STALL:
    - Same outputs as the load-use hazard; lu_cnt decrements.
    - Exit to RUN after the cycle in which lu_cnt==1.
  - P5 imem wait (inst_resp=0, RUN):
    - load_pc=0, rst_stage[0]=1; downstream stage registers load normally.
- Load-use and imem wait in the same cycle: load-use outputs apply; rst_stage[0] stays 0 so IF/ID holds.
- Counters:
  - Update on rising edge.
  - Saturate at all-ones and never wrap.
  - flush_cnt increments at most once per cycle.
- Latency: all outputs except the counters are combinational from inputs and state; no added cycle.

Test Plan:
- Reset: drive rst=0 mid-SQUASH with counters at 7 -> immediately inst_read=0, load_stage=0000, rst_stage=1111, counters 0; after release, first cycle with inst_resp=1 -> all load_stage=1111, state RUN.
- Dmem miss: data_req=1 with data_resp low for 3 cycles, then high -> load_pc=0, load_stage=0000 for exactly 3 cycles, stall_cnt=3, then defaults; a redirect asserted throughout flushes only on the 4th cycle.
- Load-use: ex_is_load=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 -> one cycle load_pc=0, load_stage[0]=0, rst_stage[1]=1; repeat with ex_rd=0, or with id_uses_rs1=0 -> no stall.
- Squash: redirect=1 with inst_resp=0 -> rst_stage=0011, load_pc=1, flush_cnt=1; 2 cycles later inst_resp=1 -> rst_stage[0]=1, load_pc=0, flush_cnt=2; next inst_resp is accepted normally.
- Parametrised build NUM_STAGES=7, BR_RESOLVE_STAGE=3, LOAD_USE_BUBBLES=3: load-use -> 3 consecutive bubble cycles; redirect in 2nd bubble -> rst_stage=000111, LU_STALL abandoned.
- Saturation: CNT_W=4, hold a dmem stall for 20 cycles -> stall_cnt stops at 15.
